// File: rtl/servo_pkg.sv
// Shared constants and types for the switch-commanded servo target slewer.
// The four target positions are the compare values fed to the 50 Hz pwm block.
package servo_pkg;

    localparam logic [7:0] POS0 = 8'd60;
    localparam logic [7:0] POS1 = 8'd100;
    localparam logic [7:0] POS2 = 8'd160;
    localparam logic [7:0] POS3 = 8'd230;

    typedef enum logic {
        IDLE,
        SLEW
    } slew_state_t;

    function automatic logic [7:0] pos_lut(input logic [1:0] idx);
        case (idx)
            2'd0:    return POS0;
            2'd1:    return POS1;
            2'd2:    return POS2;
            default: return POS3;
        endcase
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchronizer, per-bit debounce counter and registered rising-edge
// detect. A level must persist DEB_MAX+1 cycles before it is accepted.
module switch_debounce #(
    parameter int               WIDTH   = 4,
    parameter int               CNT_W   = 20,
    parameter logic [CNT_W-1:0] DEB_MAX = 20'd269_999
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [WIDTH-1:0] psw,
    output logic [WIDTH-1:0] press
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_stable;
    logic [WIDTH-1:0] r_stable_d;
    logic [WIDTH-1:0] r_press;
    logic [CNT_W-1:0] r_cnt [WIDTH];

    // NOTE: state uses <= so every flop samples pre-edge values, which is what
    // lets r_sync2 lag r_sync1 by a full cycle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_stable   <= '0;
            r_stable_d <= '0;
            r_press    <= '0;
            // NOTE: the counter array is flops, not RAM, and must clear on reset
            // so a level has to persist a full interval after reset.
            for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1    <= psw;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            r_press    <= r_stable & ~r_stable_d;
            for (int i = 0; i < WIDTH; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == DEB_MAX) begin
                    r_stable[i] <= r_sync2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign press = r_press;

endmodule

// File: rtl/servo_target_slewer.sv
// Latches a switch-selected target position and walks compare toward it by
// one count per step interval, so the pwm duty never jumps.
module servo_target_slewer
    import servo_pkg::*;
#(
    parameter int               CNT_W    = 20,
    parameter logic [CNT_W-1:0] DEB_MAX  = 20'd269_999,
    parameter logic [CNT_W-1:0] STEP_MAX = 20'd269_999
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [3:0] psw,
    output logic [7:0] compare,
    output logic [1:0] target_idx,
    output logic       busy,
    output logic       done
);

    logic [3:0]       w_press;
    logic             w_any;
    logic [1:0]       w_sel_idx;
    logic [7:0]       w_tgt;
    logic [7:0]       w_next;
    logic             w_tick;

    slew_state_t      r_state;
    logic [7:0]       r_compare;
    logic [1:0]       r_target_idx;
    logic [CNT_W-1:0] r_step_cnt;
    logic             r_busy;
    logic             r_done;

    switch_debounce #(
        .WIDTH   (4),
        .CNT_W   (CNT_W),
        .DEB_MAX (DEB_MAX)
    ) u_debounce (
        .clk   (clk),
        .nrst  (nrst),
        .psw   (psw),
        .press (w_press)
    );

    // NOTE: default first so every path assigns w_sel_idx and no latch forms.
    always_comb begin
        w_sel_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_press[i]) w_sel_idx = 2'(i);
        end
    end

    // A fresh press overrides the latched target in the same cycle it arrives.
    assign w_any  = |w_press;
    assign w_tgt  = w_any ? pos_lut(w_sel_idx) : pos_lut(r_target_idx);
    assign w_tick = (r_step_cnt == STEP_MAX);
    assign w_next = (r_compare < w_tgt) ? r_compare + 8'd1 : r_compare - 8'd1;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state      <= IDLE;
            r_compare    <= POS0;
            r_target_idx <= 2'd0;
            r_step_cnt   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_target_idx <= w_sel_idx;
                        if (w_tgt != r_compare) begin
                            r_step_cnt <= '0;
                            r_state    <= SLEW;
                            r_busy     <= 1'b1;
                        end
                    end
                end
                SLEW: begin
                    if (w_any) r_target_idx <= w_sel_idx;
                    r_step_cnt <= w_tick ? '0 : r_step_cnt + CNT_W'(1);
                    // Retarget onto the current position ends the move at once.
                    if (w_tgt == r_compare) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_tick) begin
                        r_compare <= w_next;
                        if (w_next == w_tgt) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign compare    = r_compare;
    assign target_idx = r_target_idx;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_servo_target_slewer.sv
// Directed bench for servo_target_slewer: stimulus pushes expected compare
// steps into a queue; a monitor pops one entry per compare change or done pulse.
module tb_servo_target_slewer;

    typedef struct {
        logic [7:0] cmp;
        logic       done;
        logic       busy;
        logic [1:0] idx;
    } exp_t;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic [3:0] psw = 4'd0;
    logic [7:0] compare;
    logic [1:0] target_idx;
    logic       busy;
    logic       done;

    int         n_tests = 0;
    int         n_fail = 0;
    int         n_done = 0;
    logic [7:0] last_cmp = 8'd60;
    exp_t       exp_q[$];
    exp_t       mon_e;

    always #5 clk = ~clk;

    servo_target_slewer #(
        .CNT_W    (20),
        .DEB_MAX  (20'd4),
        .STEP_MAX (20'd3)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .psw        (psw),
        .compare    (compare),
        .target_idx (target_idx),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every compare change or done pulse must match the queue head.
    always @(negedge clk) begin
        if (nrst) begin
            if (done) n_done++;
            if (compare != last_cmp || done) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_event: compare=%0d done=%0d, expected no event (t=%0t)",
                             compare, done, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("evt_compare", 32'(compare), 32'(mon_e.cmp));
                    check("evt_done", 32'(done), 32'(mon_e.done));
                    check("evt_busy", 32'(busy), 32'(mon_e.busy));
                    check("evt_target_idx", 32'(target_idx), 32'(mon_e.idx));
                end
            end
        end
        last_cmp = compare;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_steps(input logic [7:0] cur, input logic [7:0] dst,
                              input logic [1:0] idx, input bit fin);
        exp_t       e;
        logic [7:0] v;
        v = cur;
        while (v != dst) begin
            v      = (v < dst) ? v + 8'd1 : v - 8'd1;
            e.cmp  = v;
            e.idx  = idx;
            e.done = fin && (v == dst);
            e.busy = !e.done;
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        nrst = 1'b0;
        psw  = 4'd0;
        tick(3);
        nrst = 1'b1;
        tick(2);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < budget) begin
            tick(1);
            k++;
        end
        check(name, 32'(k < budget), 32'd1);
    endtask

    task automatic wait_cmp(input logic [7:0] v, input int budget, input string name);
        int k;
        k = 0;
        while (compare != v && k < budget) begin
            tick(1);
            k++;
        end
        check(name, 32'(k < budget), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int low;
        int hi;
        int k;

        // Reset held with switches toggling.
        for (int i = 0; i < 8; i++) begin
            psw = 4'(i * 5);
            tick(1);
            check("rst_compare", 32'(compare), 32'd60);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_target_idx", 32'(target_idx), 32'd0);
        end
        psw  = 4'd0;
        nrst = 1'b1;
        tick(20);
        check("post_rst_compare", 32'(compare), 32'd60);
        check("post_rst_busy", 32'(busy), 32'd0);

        // Press psw[1]: latch after 9 edges, first step 4 edges later.
        d0 = n_done;
        push_steps(8'd60, 8'd100, 2'd1, 1'b1);
        psw = 4'b0010;
        tick(8);
        check("latency_idx_before", 32'(target_idx), 32'd0);
        check("latency_busy_before", 32'(busy), 32'd0);
        tick(1);
        check("latency_idx_at", 32'(target_idx), 32'd1);
        check("latency_busy_at", 32'(busy), 32'd1);
        tick(1);
        psw = 4'd0;
        tick(2);
        check("first_step_before", 32'(compare), 32'd60);
        tick(1);
        check("first_step_at", 32'(compare), 32'd61);
        wait_idle(200, "s1_timeout");
        check("s1_final_compare", 32'(compare), 32'd100);
        check("s1_final_busy", 32'(busy), 32'd0);
        check("s1_done_count", 32'(n_done - d0), 32'd1);

        // Bounce shorter than the debounce interval is ignored.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            psw[3] = ~psw[3];
            tick(3);
        end
        psw = 4'd0;
        tick(20);
        check("bounce_compare", 32'(compare), 32'd60);
        check("bounce_busy", 32'(busy), 32'd0);
        check("bounce_idx", 32'(target_idx), 32'd0);
        d0 = n_done;
        push_steps(8'd60, 8'd230, 2'd3, 1'b1);
        psw = 4'b1000;
        tick(8);
        psw = 4'd0;
        wait_idle(800, "full_move_timeout");
        check("full_move_compare", 32'(compare), 32'd230);
        check("full_move_done_count", 32'(n_done - d0), 32'd1);

        // Retarget mid-slew: overshoot to 82 during the latch latency, then back to 60.
        do_reset();
        push_steps(8'd60, 8'd80, 2'd3, 1'b0);
        psw = 4'b1000;
        tick(10);
        psw = 4'd0;
        wait_cmp(8'd80, 200, "rt_reach_80");
        d0 = n_done;
        psw = 4'b0001;
        push_steps(8'd80, 8'd82, 2'd3, 1'b0);
        push_steps(8'd82, 8'd60, 2'd0, 1'b1);
        low = 0;
        k = 0;
        while (k < 300) begin
            tick(1);
            k++;
            if (k == 10) psw = 4'd0;
            if (done) break;
            if (!busy) low++;
        end
        check("rt_done_seen", 32'(done), 32'd1);
        check("rt_busy_gaps", 32'(low), 32'd0);
        check("rt_compare", 32'(compare), 32'd60);
        check("rt_idx", 32'(target_idx), 32'd0);
        tick(2);
        check("rt_done_count", 32'(n_done - d0), 32'd1);

        // Simultaneous press: lowest index wins; re-press at target is silent.
        do_reset();
        push_steps(8'd60, 8'd100, 2'd1, 1'b1);
        psw = 4'b0110;
        tick(10);
        psw = 4'd0;
        wait_idle(250, "simul_timeout");
        check("simul_idx", 32'(target_idx), 32'd1);
        check("simul_compare", 32'(compare), 32'd100);
        d0 = n_done;
        hi = 0;
        psw = 4'b0010;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (i == 10) psw = 4'd0;
            if (busy) hi++;
        end
        check("repress_busy", 32'(hi), 32'd0);
        check("repress_done", 32'(n_done - d0), 32'd0);
        check("repress_idx", 32'(target_idx), 32'd1);

        // Reset mid-slew returns compare to 60 without a clock edge.
        do_reset();
        push_steps(8'd60, 8'd150, 2'd3, 1'b0);
        psw = 4'b1000;
        tick(10);
        psw = 4'd0;
        wait_cmp(8'd150, 500, "mid_reach_150");
        #1;
        nrst = 1'b0;
        #1;
        check("async_rst_compare", 32'(compare), 32'd60);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_idx", 32'(target_idx), 32'd0);
        tick(3);
        nrst = 1'b1;
        tick(20);
        check("after_rst_compare", 32'(compare), 32'd60);
        check("after_rst_busy", 32'(busy), 32'd0);
        push_steps(8'd60, 8'd100, 2'd1, 1'b1);
        psw = 4'b0010;
        tick(10);
        psw = 4'd0;
        wait_idle(250, "after_rst_move_timeout");
        check("after_rst_move_compare", 32'(compare), 32'd100);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
